// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter: FSM/owner encodings
// and default bus widths.
package mem_arbiter_pkg;

  localparam int unsigned ROM_ADDR_BUS = 32;
  localparam int unsigned REG_BUS      = 32;

  localparam int unsigned DEF_ADDR_W = ROM_ADDR_BUS;
  localparam int unsigned DEF_DATA_W = REG_BUS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto a single RAM port,
// with MEM-stage priority, variable-latency handshake and per-requester stalls.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_be,
  output logic                mem_ack,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                ram_req,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_be,
  input  logic                ram_ack,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e state_q, state_d;
  owner_e owner_q;
  logic   drop_q;

  logic grant_mem;
  logic grant_if;
  logic capture;
  logic flush_hit;
  logic drop_eff;

  // Next-state and grant decode
  always_comb begin
    state_d   = state_q;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          grant_mem = 1'b1;
          state_d   = BUSY;
        end else if (if_req) begin
          grant_if = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (ram_ack) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A flush only matters for a fetch that is being granted or is in flight
  assign flush_hit = if_flush & (grant_if | ((state_q == BUSY) & (owner_q == OWN_IF)));
  assign drop_eff  = drop_q | flush_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched RAM command, held stable for the whole BUSY phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= OWN_IF;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_be    <= '0;
    end else if (grant_mem) begin
      owner_q   <= OWN_MEM;
      ram_we    <= mem_we;
      ram_addr  <= mem_addr;
      ram_wdata <= mem_wdata;
      ram_be    <= mem_be;
    end else if (grant_if) begin
      owner_q   <= OWN_IF;
      ram_we    <= 1'b0;
      ram_addr  <= if_addr;
      ram_wdata <= '0;
      ram_be    <= {BE_W{1'b1}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_req <= 1'b0;
    end else if (grant_mem || grant_if) begin
      ram_req <= 1'b1;
    end else if (capture) begin
      ram_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else if (state_q == DONE) begin
      drop_q <= 1'b0;
    end else if (flush_hit) begin
      drop_q <= 1'b1;
    end
  end

  // Ack pulses land in DONE; a dropped fetch neither acks nor updates if_rdata
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
    end else begin
      if_ack  <= capture & (owner_q == OWN_IF) & ~drop_eff;
      mem_ack <= capture & (owner_q == OWN_MEM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else if (capture) begin
      if ((owner_q == OWN_IF) && !drop_eff) begin
        if_rdata <= ram_rdata;
      end
      if ((owner_q == OWN_MEM) && !ram_we) begin
        mem_rdata <= ram_rdata;
      end
    end
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand-written contention, back-to-back, and reset-in-flight sequences.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_ack;
  logic [31:0] ram_rdata;
  logic        stall_if;
  logic        stall_mem;

  int total;
  int bad;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_be    (ram_be),
    .ram_ack   (ram_ack),
    .ram_rdata (ram_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flush: 0 none, 1 pulse in first BUSY cycle, 2 pulse in the grant cycle
  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdata;
    int          flush;
    logic        exp_ack;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    if_flush  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    ram_ack   = 1'b0;
    ram_rdata = '0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    clear_inputs();
    if (v.is_mem) begin
      mem_req   = 1'b1;
      mem_we    = v.we;
      mem_addr  = v.addr;
      mem_wdata = v.wdata;
      mem_be    = v.be;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    if (v.flush == 2) if_flush = 1'b1;
    #1;
    chk($sformatf("v%0d stall_req", i), 32'(v.is_mem ? stall_mem : stall_if), 32'd1);
    chk($sformatf("v%0d ram_req_idle", i), 32'(ram_req), 32'd0);
    tick();
    if_flush = 1'b0;
    for (int w = 0; w <= v.waits; w++) begin
      if (w == 0 && v.flush == 1) if_flush = 1'b1;
      if (w == v.waits) begin
        ram_ack   = 1'b1;
        ram_rdata = v.rdata;
      end
      #1;
      chk($sformatf("v%0d ram_req w%0d", i, w), 32'(ram_req), 32'd1);
      chk($sformatf("v%0d ram_addr w%0d", i, w), ram_addr, v.addr);
      chk($sformatf("v%0d ram_we w%0d", i, w), 32'(ram_we), 32'(v.we));
      chk($sformatf("v%0d ram_wdata w%0d", i, w), ram_wdata, v.exp_wdata);
      chk($sformatf("v%0d ram_be w%0d", i, w), 32'(ram_be), 32'(v.exp_be));
      tick();
      if_flush  = 1'b0;
      ram_ack   = 1'b0;
      ram_rdata = '0;
    end
    #1;
    chk($sformatf("v%0d ack", i), 32'(v.is_mem ? mem_ack : if_ack), 32'(v.exp_ack));
    chk($sformatf("v%0d other_ack", i), 32'(v.is_mem ? if_ack : mem_ack), 32'd0);
    chk($sformatf("v%0d rdata", i), v.is_mem ? mem_rdata : if_rdata, v.exp_rdata);
    chk($sformatf("v%0d ram_req_done", i), 32'(ram_req), 32'd0);
    tick();
    clear_inputs();
    #1;
    chk($sformatf("v%0d ack_cleared", i), 32'(if_ack | mem_ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    //          mem we addr        wdata         be    w  rdata         fl ack exp_rdata     exp_wdata     exp_be
    vecs[0] = '{1'b0, 1'b0, 32'h04,  32'h0,        4'h0, 0, 32'h3C010001, 0, 1'b1, 32'h3C010001, 32'h0,        4'hF};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'hF, 1, 32'h12345678, 0, 1'b1, 32'h12345678, 32'h0,        4'hF};
    vecs[2] = '{1'b1, 1'b1, 32'h20,  32'hDEADBEEF, 4'h3, 3, 32'hFFFF0000, 0, 1'b1, 32'h12345678, 32'hDEADBEEF, 4'h3};
    vecs[3] = '{1'b0, 1'b0, 32'h08,  32'h0,        4'h0, 2, 32'hAAAA5555, 1, 1'b0, 32'h3C010001, 32'h0,        4'hF};
    vecs[4] = '{1'b0, 1'b0, 32'h10,  32'h0,        4'h0, 1, 32'h00000055, 2, 1'b0, 32'h3C010001, 32'h0,        4'hF};
    vecs[5] = '{1'b0, 1'b0, 32'h0C,  32'h0,        4'h0, 0, 32'h00000013, 0, 1'b1, 32'h00000013, 32'h0,        4'hF};
    vecs[6] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        4'hF, 0, 32'hCAFEF00D, 1, 1'b1, 32'hCAFEF00D, 32'h0,        4'hF};
    vecs[7] = '{1'b0, 1'b0, 32'h14,  32'h0,        4'h0, 1, 32'h00000020, 0, 1'b1, 32'h00000020, 32'h0,        4'hF};

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst ram_req", 32'(ram_req), 32'd0);
    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst ram_addr", ram_addr, 32'd0);
    chk("rst ram_wdata", ram_wdata, 32'd0);
    chk("rst ram_be", 32'(ram_be), 32'd0);
    chk("rst acks", 32'({if_ack, mem_ack}), 32'd0);
    chk("rst if_rdata", if_rdata, 32'd0);
    chk("rst mem_rdata", mem_rdata, 32'd0);
    tick();

    for (int i = 0; i < NV; i++) run_vec(i);

    // Contention: both request in IDLE, MEM first, then IF
    clear_inputs();
    if_req   = 1'b1;
    if_addr  = 32'h40;
    mem_req  = 1'b1;
    mem_addr = 32'h100;
    mem_be   = 4'hF;
    tick();
    ram_ack   = 1'b1;
    ram_rdata = 32'h00000011;
    #1;
    chk("ct ram_addr mem", ram_addr, 32'h100);
    chk("ct stall_if busy", 32'(stall_if), 32'd1);
    tick();
    ram_ack = 1'b0;
    #1;
    chk("ct mem_ack", 32'(mem_ack), 32'd1);
    chk("ct if_ack early", 32'(if_ack), 32'd0);
    chk("ct mem_rdata", mem_rdata, 32'h00000011);
    chk("ct stall_if done", 32'(stall_if), 32'd1);
    tick();
    mem_req = 1'b0;
    #1;
    chk("ct ram_req idle", 32'(ram_req), 32'd0);
    tick();
    ram_ack   = 1'b1;
    ram_rdata = 32'h00000022;
    #1;
    chk("ct ram_req if", 32'(ram_req), 32'd1);
    chk("ct ram_addr if", ram_addr, 32'h40);
    chk("ct ram_be if", 32'(ram_be), 32'hF);
    tick();
    ram_ack = 1'b0;
    #1;
    chk("ct if_ack", 32'(if_ack), 32'd1);
    chk("ct if_rdata", if_rdata, 32'h00000022);
    tick();
    clear_inputs();
    #1;

    // Back-to-back fetches with req held continuously and zero-wait RAM
    for (int k = 0; k < 3; k++) begin
      if_req  = 1'b1;
      if_addr = 32'(k * 4);
      #1;
      chk($sformatf("bb%0d idle ram_req", k), 32'(ram_req), 32'd0);
      chk($sformatf("bb%0d idle if_ack", k), 32'(if_ack), 32'd0);
      tick();
      ram_ack   = 1'b1;
      ram_rdata = 32'h1000 + 32'(k);
      #1;
      chk($sformatf("bb%0d ram_addr", k), ram_addr, 32'(k * 4));
      chk($sformatf("bb%0d busy if_ack", k), 32'(if_ack), 32'd0);
      tick();
      ram_ack   = 1'b0;
      ram_rdata = '0;
      #1;
      chk($sformatf("bb%0d if_ack", k), 32'(if_ack), 32'd1);
      chk($sformatf("bb%0d if_rdata", k), if_rdata, 32'h1000 + 32'(k));
      chk($sformatf("bb%0d done ram_req", k), 32'(ram_req), 32'd0);
      tick();
    end
    clear_inputs();
    tick();

    // Async reset in the middle of BUSY, then a stray ram_ack
    if_req  = 1'b1;
    if_addr = 32'h80;
    tick();
    #1;
    chk("rb ram_req busy", 32'(ram_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rb ram_req async", 32'(ram_req), 32'd0);
    chk("rb ram_addr async", ram_addr, 32'd0);
    chk("rb ram_be async", 32'(ram_be), 32'd0);
    chk("rb if_rdata async", if_rdata, 32'd0);
    chk("rb mem_rdata async", mem_rdata, 32'd0);
    tick();
    rst       = 1'b0;
    if_req    = 1'b0;
    ram_ack   = 1'b1;
    ram_rdata = 32'hBADBAD00;
    tick();
    ram_ack = 1'b0;
    #1;
    chk("rb late ack if_ack", 32'(if_ack), 32'd0);
    chk("rb late ack ram_req", 32'(ram_req), 32'd0);
    tick();
    chk("rb late ack if_ack2", 32'(if_ack), 32'd0);
    chk("rb late if_rdata", if_rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the core's single unified memory port between the instruction-fetch requester (pc_reg/IF_ID side) and the MEM-stage load/store requester. It serialises accesses, holds the memory handshake through variable-latency responses, and generates per-requester stall signals for the pipeline. It sits between CORE_TOP's fetch/MEM stages and the external RAM.

## Interface
Parameters:
- ADDR_W, 32, address width for requesters and RAM
- DATA_W, 32, data width; byte enables are DATA_W/8 bits

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_flush  in  1  discard the in-flight fetch result (branch taken)
- if_ack  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- mem_req  in  1  load/store request, held until mem_ack
- mem_we  in  1  1 = store
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_be  in  DATA_W/8  store byte enables
- mem_ack  out  1  one-cycle pulse; mem_rdata valid for loads
- mem_rdata  out  DATA_W  load data
- ram_req  out  1  memory request, held until ram_ack
- ram_we, ram_addr, ram_wdata, ram_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered command
- ram_ack  in  1  one-cycle completion pulse from memory
- ram_rdata  in  DATA_W  read data, valid with ram_ack
- stall_if  out  1  if_req & ~if_ack (combinational)
- stall_mem  out  1  mem_req & ~mem_ack (combinational)

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if mem_req, grant MEM; else if if_req, grant IF; else stay. MEM has fixed priority (older instruction). On grant, latch owner, we, addr, wdata, be (IF grant: we=0, be=all ones) and go BUSY.
- BUSY: ram_req=1 with latched command. On ram_ack, latch ram_rdata into owner's rdata register, go DONE.
- DONE: pulse owner's ack; requests ignored this cycle; go IDLE. Requesters must drop or change the request in the cycle after ack.
- Flush: if_flush while owner=IF in BUSY (or same cycle as grant) sets drop flag; the RAM transaction completes normally, but if_ack is suppressed in DONE and if_rdata is not updated. if_flush in IDLE, or while owner=MEM, has no effect. Drop flag is cleared on entering IDLE.
- A request deasserted before its ack is a protocol error; the transaction still completes and the ack pulse is still generated.

## Timing
- Reset (async): state=IDLE, ram_req=0, ram_we=0, ram_addr/wdata/be=0, if_ack=mem_ack=0, if_rdata=mem_rdata=0, drop=0.
- Request seen in IDLE at cycle 0 -> ram_req high from cycle 1. ram_ack at cycle N -> ack pulse at cycle N+1 -> IDLE at N+2. With zero-wait RAM (ram_ack in cycle 1), ack at cycle 2; minimum 3 cycles per access.
- ram_req deasserts the cycle after ram_ack; command bus stable throughout BUSY.
- Simultaneous if_req and mem_req in IDLE: MEM granted; IF waits with stall_if high and is granted in the next IDLE.
- Reset during BUSY: ram_req drops immediately; any late ram_ack while IDLE is ignored.

## Structure
- Shared package/defines file: state encodings (IDLE/BUSY/DONE), owner encoding (OWN_IF/OWN_MEM), default widths alongside existing RomAddrBus/RegBus defines.
- Single module; no sub-modules required. Requester-side muxing is inline.

## Test plan
- Single fetch, zero-wait RAM: if_req, addr 0x04, ram_ack in cycle 1 with 0x3C010001 -> ram_addr=0x04, if_ack at cycle 2, if_rdata=0x3C010001, stall_if high cycles 0-1.
- Contention: if_req and mem_req (load, 0x100) both at cycle 0 -> MEM served first (mem_ack cycle 2), then IF granted at cycle 3, ram_addr switches to IF address.
- Store with 3-wait RAM: mem_we=1, addr 0x20, wdata 0xDEADBEEF, be=4'b0011 -> ram_we/addr/wdata/be held 4 cycles, mem_ack one cycle after ram_ack, mem_rdata unchanged.
- Flush: if_flush pulsed while IF in BUSY -> RAM transaction completes, if_ack never pulses, if_rdata retains old value, next if_req served normally.
- Async reset asserted mid-BUSY -> ram_req low immediately (before next clk edge), all outputs at reset values; subsequent ram_ack ignored.
- Back-to-back fetches 0x00,0x04,0x08 with zero-wait RAM -> if_ack every 3 cycles, correct data each time, no duplicate grant in DONE.
